conv_frame_streamer: RTL and testbench

//  Transmit side of the conv pixel stream. Reads one NUM_CHANNELS-wide image frame from an external

---
 rtl/conv_frame_streamer.sv | 153 +++++++++++++++
 tb/tb_conv_frame_streamer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_streamer.sv
// Streams one frame from a sync-read frame buffer in raster order. Reads go through a two-stage
// pipeline that carries row/col tags to the conv pixel inputs.
module conv_frame_streamer #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_WIDTH    = 4,
    parameter int IMG_HEIGHT   = 4,
    parameter int NUM_CHANNELS = 3,
    localparam int ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int ROW_W       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     hold,
    input  logic                                     abort,
    output logic                                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                    mem_rd_addr,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_rd_data,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  pixel_out_ch,
    output logic                                     valid_out,
    output logic [ROW_W-1:0]                         row_out,
    output logic [COL_W-1:0]                         col_out,
    output logic                                     frame_first,
    output logic                                     frame_last,
    output logic                                     busy,
    output logic                                     done,
    output logic [15:0]                              frame_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_WIDTH - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic                  vld_p1;
    logic [ROW_W-1:0]      row_p1;
    logic [COL_W-1:0]      col_p1;
    logic                  kill;
    logic                  last_beat;

    assign busy        = (state != S_IDLE);
    assign mem_rd_en   = (state == S_STREAM) && !hold;
    assign mem_rd_addr = rd_addr;
    assign kill        = abort && busy;
    // The final beat is on the output and nothing is left in flight behind it.
    assign last_beat   = (state == S_DRAIN) && valid_out && frame_last && !vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rd_addr     <= '0;
            row         <= '0;
            col         <= '0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state   <= S_IDLE;
                rd_addr <= '0;
                row     <= '0;
                col     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_STREAM;
                            rd_addr <= '0;
                            row     <= '0;
                            col     <= '0;
                        end
                    end
                    S_STREAM: begin
                        if (mem_rd_en) begin
                            if (rd_addr == ADDR_LAST) begin
                                state   <= S_DRAIN;
                                rd_addr <= '0;
                                row     <= '0;
                                col     <= '0;
                            end else begin
                                rd_addr <= rd_addr + 1'b1;
                                if (col == COL_LAST) begin
                                    col <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (last_beat) begin
                            state       <= S_IDLE;
                            done        <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Stage 1: read issued, tags captured alongside the outstanding request
    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            row_p1 <= row;
            col_p1 <= col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= mem_rd_en && !kill;
        end
    end

    // Stage 2: read data returns and is registered with its tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out_ch <= '0;
            valid_out    <= 1'b0;
            row_out      <= '0;
            col_out      <= '0;
            frame_first  <= 1'b0;
            frame_last   <= 1'b0;
        end else if (kill) begin
            valid_out   <= 1'b0;
            frame_first <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            valid_out   <= vld_p1;
            frame_first <= vld_p1 && (row_p1 == '0) && (col_p1 == '0);
            frame_last  <= vld_p1 && (row_p1 == ROW_LAST) && (col_p1 == COL_LAST);
            if (vld_p1) begin
                pixel_out_ch <= mem_rd_data;
                row_out      <= row_p1;
                col_out      <= col_p1;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Bench for conv_frame_streamer: frame-level reference model checked every cycle plus literal timing pins.
module tb_conv_frame_streamer;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NC = 3;
    localparam int N  = W * H;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   hold = 1'b0;
    logic                   abort = 1'b0;
    logic                   mem_rd_en;
    logic [3:0]             mem_rd_addr;
    logic [NC-1:0][DW-1:0]  mem_rd_data;
    logic [NC-1:0][DW-1:0]  pixel_out_ch;
    logic                   valid_out;
    logic [1:0]             row_out;
    logic [1:0]             col_out;
    logic                   frame_first;
    logic                   frame_last;
    logic                   busy;
    logic                   done;
    logic [15:0]            frame_count;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] memv [N][NC];
    int beat_idx = 0;
    int exp_frames = 0;
    bit exp_done = 1'b0;
    int abort_cnt = 0;
    int seen_abort = 0;

    conv_frame_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .pixel_out_ch(pixel_out_ch), .valid_out(valid_out), .row_out(row_out), .col_out(col_out),
        .frame_first(frame_first), .frame_last(frame_last), .busy(busy), .done(done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Sync-read frame buffer: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int c = 0; c < NC; c++) mem_rd_data[c] <= memv[mem_rd_addr][c];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit rnd);
        for (int a = 0; a < N; a++)
            for (int c = 0; c < NC; c++)
                memv[a][c] = rnd ? DW'($urandom_range(0, 255)) : DW'(a + 16 * c);
    endtask

    // Reference: beat k of a frame is memory word k at (k/W, k%W); done follows the last beat.
    task automatic check_cycle();
        if (!rst_n) begin
            beat_idx = 0;
            exp_done = 1'b0;
            exp_frames = 0;
            seen_abort = abort_cnt;
        end else begin
            if (abort_cnt != seen_abort) begin
                seen_abort = abort_cnt;
                beat_idx = 0;
                exp_done = 1'b0;
            end
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                exp_frames = (exp_frames + 1) % 65536;
                beat_idx = 0;
            end
            chk("frame_count", 32'(frame_count), 32'(exp_frames));
            if (valid_out) begin
                if (beat_idx >= N) begin
                    chk("extra_beat", 32'(beat_idx), 32'(N - 1));
                end else begin
                    for (int c = 0; c < NC; c++)
                        chk("pixel", 32'(pixel_out_ch[c]), 32'(memv[beat_idx][c]));
                    chk("row", 32'(row_out), 32'(beat_idx / W));
                    chk("col", 32'(col_out), 32'(beat_idx % W));
                    chk("first", 32'(frame_first), 32'(beat_idx == 0));
                    chk("last", 32'(frame_last), 32'(beat_idx == N - 1));
                end
                exp_done = (beat_idx == N - 1);
                beat_idx++;
            end else begin
                exp_done = 1'b0;
            end
        end
    endtask

    // mode: 0 no hold, 1 alternate hold, 2 random hold, 3 random hold plus stray start pulses.
    // Returns while sitting in the done cycle so a following call can start back-to-back.
    task automatic run_frame(input int mode, output int first_c, output int done_c, output int beats);
        int c;
        first_c = -1;
        done_c = -1;
        beats = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (1) begin
            if (done) begin
                done_c = c;
                start = 1'b0;
                break;
            end
            if (c > 200) begin
                chk("frame_timeout", 32'(c), 32'(0));
                break;
            end
            hold  = (mode == 1) ? (c % 2 == 0) : (mode >= 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            start = (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (valid_out) begin
                beats++;
                if (first_c < 0) first_c = c;
            end
            tick();
            c++;
        end
        hold = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int fc, dc, nb, n, c;
        fork
            forever begin
                @(negedge clk);
                check_cycle();
            end
        join_none

        fill(1'b0);
        #3;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_pixel", 32'(pixel_out_ch), 0);
        chk("rst_count", 32'(frame_count), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Frame 1 with literal timing pins
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_rd_en", 32'(mem_rd_en), 1);
        chk("c1_addr", 32'(mem_rd_addr), 0);
        tick();
        chk("c2_addr", 32'(mem_rd_addr), 1);
        chk("c2_valid", 32'(valid_out), 0);
        tick();
        chk("c3_valid", 32'(valid_out), 1);
        chk("c3_ch1", 32'(pixel_out_ch[1]), 16);
        chk("c3_ch2", 32'(pixel_out_ch[2]), 32);
        chk("c3_first", 32'(frame_first), 1);
        c = 3;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        chk("f1_done_cycle", 32'(c), 19);
        chk("f1_count", 32'(frame_count), 1);
        chk("f1_busy_done", 32'(busy), 0);

        // Back-to-back start in the done cycle
        run_frame(0, fc, dc, nb);
        chk("b2b_first", 32'(fc), 3);
        chk("b2b_done", 32'(dc), 19);
        chk("b2b_beats", 32'(nb), 16);
        chk("b2b_count", 32'(frame_count), 2);

        // Alternating hold on random data
        tick();
        fill(1'b1);
        run_frame(1, fc, dc, nb);
        chk("hold_beats", 32'(nb), 16);
        chk("hold_count", 32'(frame_count), 3);

        // Abort after five beats
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (valid_out) n++;
            if (n == 5) break;
            tick();
        end
        chk("abort_reach5", 32'(n), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        abort_cnt++;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid_out), 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_out || done) n++;
            tick();
        end
        chk("abort_quiet", 32'(n), 0);
        chk("abort_count", 32'(frame_count), 3);
        fill(1'b1);
        run_frame(2, fc, dc, nb);
        chk("replay_beats", 32'(nb), 16);
        chk("replay_count", 32'(frame_count), 4);

        // Abort in IDLE, then stray start pulses mid-frame
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        fill(1'b1);
        run_frame(3, fc, dc, nb);
        chk("spam_beats", 32'(nb), 16);
        chk("spam_count", 32'(frame_count), 5);
        tick();
        chk("spam_idle", 32'(busy), 0);

        // Async reset at beat 7
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (valid_out) n++;
            if (n == 7) break;
            tick();
        end
        chk("rst_reach7", 32'(n), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rd_en", 32'(mem_rd_en), 0);
        chk("arst_pixel", 32'(pixel_out_ch), 0);
        chk("arst_rowcol", 32'({row_out, col_out}), 0);
        chk("arst_count", 32'(frame_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        fill(1'b1);
        run_frame(0, fc, dc, nb);
        chk("post_rst_beats", 32'(nb), 16);
        chk("post_rst_first", 32'(fc), 3);
        chk("post_rst_count", 32'(frame_count), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
